// File: rtl/wb_burst_master_if.sv
// Wishbone B4 bus bundle between the burst master and a slave.
interface wb_burst_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] WB_ADR_O;
  logic [DATA_WIDTH-1:0] WB_DAT_O;
  logic [DATA_WIDTH-1:0] WB_DAT_I;
  logic                  WB_WE_O;
  logic                  WB_CYC_O;
  logic                  WB_STB_O;
  logic [2:0]            WB_CTI_O;
  logic                  WB_ACK_I;
  logic                  WB_ERR_I;
  logic                  WB_RTY_I;
  logic                  WB_STALL_I;

  modport master (
    output WB_ADR_O, WB_DAT_O, WB_WE_O, WB_CYC_O, WB_STB_O, WB_CTI_O,
    input  WB_DAT_I, WB_ACK_I, WB_ERR_I, WB_RTY_I, WB_STALL_I
  );

  modport slave (
    input  WB_ADR_O, WB_DAT_O, WB_WE_O, WB_CYC_O, WB_STB_O, WB_CTI_O,
    output WB_DAT_I, WB_ACK_I, WB_ERR_I, WB_RTY_I, WB_STALL_I
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 initiator turning single commands into classic or incrementing bursts.
// Optional per-beat watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH     = 5,
  parameter int unsigned MAX_RETRY     = 3
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT       = 255
`endif
) (
  input  logic                     WB_CLK_I,
  input  logic                     WB_RST_I,
  wb_burst_master_if.master        wb,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     cmd_we,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  output logic [WB_DATA_WIDTH-1:0] rdata,
  output logic                     rdata_valid,
  output logic                     done,
  output logic                     error
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_BEAT      = 3'd2;
  localparam logic [2:0] S_RETRY_GAP = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned RETRY_WIDTH = $clog2(MAX_RETRY + 2);

  logic [2:0]               r_state,       w_state_nxt;
  logic [WB_ADDR_WIDTH-1:0] r_addr,        w_addr_nxt;
  logic [WB_DATA_WIDTH-1:0] r_dat,         w_dat_nxt;
  logic                     r_we,          w_we_nxt;
  logic                     r_cyc,         w_cyc_nxt;
  logic                     r_stb,         w_stb_nxt;
  logic [2:0]               r_cti,         w_cti_nxt;
  logic [LEN_WIDTH-1:0]     r_rem,         w_rem_nxt;
  logic                     r_single,      w_single_nxt;
  logic [RETRY_WIDTH-1:0]   r_retry,       w_retry_nxt;
  logic [WB_DATA_WIDTH-1:0] r_rdata,       w_rdata_nxt;
  logic                     r_rdata_valid, w_rdata_valid_nxt;
  logic                     r_done,        w_done_nxt;
  logic                     r_error,       w_error_nxt;
  logic                     r_wdata_ready, w_wdata_ready_nxt;
  logic                     r_cmd_ready,   w_cmd_ready_nxt;
  logic                     w_term;
  logic [RETRY_WIDTH-1:0]   w_retry_inc;
  logic [1:0]               w_unused_addr_lsb;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned WDOG_WIDTH = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WDOG_WIDTH-1:0] r_wdog, w_wdog_nxt;
`endif

  assign w_unused_addr_lsb = cmd_addr[1:0];

  // Classic for single-beat commands, otherwise incrementing until the final beat.
  function automatic logic [2:0] f_cti(input logic single, input logic [LEN_WIDTH-1:0] rem);
    if (single) return CTI_CLASSIC;
    if (rem == LEN_WIDTH'(1)) return CTI_END;
    return CTI_INCR;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_dat_nxt         = r_dat;
    w_we_nxt          = r_we;
    w_rem_nxt         = r_rem;
    w_single_nxt      = r_single;
    w_retry_nxt       = r_retry;
    w_rdata_nxt       = r_rdata;
    w_rdata_valid_nxt = 1'b0;
    w_error_nxt       = 1'b0;
    w_term            = r_stb & ~wb.WB_STALL_I & (wb.WB_ACK_I | wb.WB_ERR_I | wb.WB_RTY_I);
    w_retry_inc       = r_retry + RETRY_WIDTH'(1);

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_addr_nxt   = {cmd_addr[WB_ADDR_WIDTH-1:2], 2'b00};
          w_rem_nxt    = cmd_len;
          w_we_nxt     = cmd_we;
          w_single_nxt = (cmd_len == LEN_WIDTH'(1));
          if (cmd_len == '0)  w_state_nxt = S_FINISH;
          else if (cmd_we)    w_state_nxt = S_FETCH;
          else                w_state_nxt = S_BEAT;
        end
      end
      S_FETCH: begin
        if (wdata_valid) begin
          w_dat_nxt   = wdata;
          w_state_nxt = S_BEAT;
        end
      end
      S_BEAT: begin
        if (w_term) begin
          if (wb.WB_ERR_I) begin
            w_state_nxt = S_FINISH;
            w_error_nxt = 1'b1;
          end else if (wb.WB_RTY_I) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc > RETRY_WIDTH'(MAX_RETRY)) begin
              w_state_nxt = S_FINISH;
              w_error_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RETRY_GAP;
            end
          end else begin
            if (!r_we) begin
              w_rdata_nxt       = wb.WB_DAT_I;
              w_rdata_valid_nxt = 1'b1;
            end
            w_addr_nxt = r_addr + WB_ADDR_WIDTH'(4);
            w_rem_nxt  = r_rem - LEN_WIDTH'(1);
            if (w_rem_nxt == '0) w_state_nxt = S_FINISH;
            else if (r_we)       w_state_nxt = S_FETCH;
            else                 w_state_nxt = S_BEAT;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (r_wdog >= WDOG_WIDTH'(TIMEOUT)) begin
          w_state_nxt = S_FINISH;
          w_error_nxt = 1'b1;
        end
`endif
      end
      S_RETRY_GAP: w_state_nxt = S_BEAT;
      S_FINISH: begin
        w_retry_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bus and handshake outputs follow the state being entered.
    w_cyc_nxt         = (w_state_nxt == S_FETCH) || (w_state_nxt == S_BEAT);
    w_stb_nxt         = (w_state_nxt == S_BEAT);
    w_wdata_ready_nxt = (w_state_nxt == S_FETCH);
    w_done_nxt        = (w_state_nxt == S_FINISH);
    w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
    w_cti_nxt         = (w_state_nxt == S_BEAT) ? f_cti(w_single_nxt, w_rem_nxt) : CTI_CLASSIC;
`ifdef WB_MASTER_TIMEOUT_EN
    w_wdog_nxt = ((r_state == S_BEAT) && (w_state_nxt == S_BEAT) && !w_term)
               ? r_wdog + WDOG_WIDTH'(1) : '0;
`endif
  end

  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_dat         <= '0;
      r_we          <= 1'b0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_cti         <= CTI_CLASSIC;
      r_rem         <= '0;
      r_single      <= 1'b0;
      r_retry       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_cmd_ready   <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_dat         <= w_dat_nxt;
      r_we          <= w_we_nxt;
      r_cyc         <= w_cyc_nxt;
      r_stb         <= w_stb_nxt;
      r_cti         <= w_cti_nxt;
      r_rem         <= w_rem_nxt;
      r_single      <= w_single_nxt;
      r_retry       <= w_retry_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_wdata_ready <= w_wdata_ready_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
`ifdef WB_MASTER_TIMEOUT_EN
      r_wdog        <= w_wdog_nxt;
`endif
    end
  end

  assign wb.WB_ADR_O = r_addr;
  assign wb.WB_DAT_O = r_dat;
  assign wb.WB_WE_O  = r_we;
  assign wb.WB_CYC_O = r_cyc;
  assign wb.WB_STB_O = r_stb;
  assign wb.WB_CTI_O = r_cti;
  assign cmd_ready   = r_cmd_ready;
  assign wdata_ready = r_wdata_ready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign error       = r_error;
endmodule
